// File: rtl/adder_pkg.sv
// Shared types and constants for the adder response block.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/adder_resp_if.sv
// Operand request channel and result response channel of adder_resp.
interface adder_resp_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

  // Initiator: issues operands and consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum
  );

  // The adder block itself.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/adder_fifo.sv
// Registered result queue; head entry is visible on dout the cycle after its push.
module adder_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                din,
  output logic [DW-1:0]                dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state: guarded push/pop, pointers wrap at DEPTH (not a power of two in general).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // State register; storage is cleared so dout reads zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/adder_resp.sv
// Add/subtract unit with a result queue and a saturating accept counter.
module adder_resp
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  adder_resp_if.slave  bus,
  output logic [15:0]  acc_count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH:0] result;
  logic           push, pop, full, empty;
  logic [CW-1:0]  count;
  logic [15:0]    acc_count_q, acc_count_d;

  // Result is WIDTH+1 bits: carry for ADD, two's-complement borrow bit for SUB.
  always_comb begin
    result = '0;
    unique case (bus.in_op)
      OP_ADD: result = {1'b0, bus.in_a} + {1'b0, bus.in_b} + (WIDTH+1)'(bus.in_cin);
      OP_SUB: result = {1'b0, bus.in_a} - {1'b0, bus.in_b};
      default: result = '0;
    endcase
  end

  // in_ready depends only on occupancy and reset, never on out_ready.
  assign bus.in_ready  = !rst && !full;
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !empty;
  assign pop           = bus.out_valid && bus.out_ready;

  adder_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (result),
    .dout  (bus.out_sum),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Accept counter sticks at all-ones.
  always_comb begin
    acc_count_d = acc_count_q;
    if (push && (acc_count_q != 16'hFFFF)) begin
      acc_count_d = acc_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count_q <= '0;
    end else begin
      acc_count_q <= acc_count_d;
    end
  end

  assign acc_count = acc_count_q;

  full_matches_count: assert property (@(posedge clk) disable iff (rst)
    full == (count == CW'(DEPTH)));

endmodule

// File: tb/tb_adder_resp.sv
// Self-checking bench for adder_resp: vector table, corner sequences, random vs queue model.
module tb_adder_resp;
  import adder_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] acc_count;

  adder_resp_if #(.WIDTH(W)) bus ();

  adder_resp #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .acc_count (acc_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_q[$];
  int acc_exp = 0;

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  localparam int NV = 8;
  vec_t vec[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer math reduced modulo 2^(W+1).
  function automatic int ref_result(input op_e op, input int a, input int b, input int cin);
    int m;
    m = 1 << (W + 1);
    if (op == OP_ADD) return (a + b + cin) % m;
    return (a - b + m) % m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one edge and update the queue model with what the edge should do.
  task automatic tick();
    bit acc_now, pop_now;
    int res;
    acc_now = !rst && bus.in_valid && (model_q.size() < D);
    pop_now = !rst && bus.out_ready && (model_q.size() > 0);
    res = ref_result(bus.in_op, int'(bus.in_a), int'(bus.in_b), int'(bus.in_cin));
    step();
    if (rst) begin
      model_q.delete();
      acc_exp = 0;
    end else begin
      if (pop_now) void'(model_q.pop_front());
      if (acc_now) begin
        model_q.push_back(res);
        if (acc_exp < 65535) acc_exp++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(model_q.size() > 0));
    check({tag, ".ready"}, 32'(bus.in_ready), 32'(!rst && (model_q.size() < D)));
    if (model_q.size() > 0) check({tag, ".sum"}, 32'(bus.out_sum), 32'(model_q[0]));
    check({tag, ".acc"}, 32'(acc_count), 32'(acc_exp));
  endtask

  task automatic drive(input op_e op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic valid);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = valid;
  endtask

  initial begin
    vec[0] = '{OP_ADD, 8'hFF, 8'h01, 1'b1, 9'h101};
    vec[1] = '{OP_SUB, 8'h05, 8'h07, 1'b1, 9'h1FE};
    vec[2] = '{OP_SUB, 8'h07, 8'h05, 1'b0, 9'h002};
    vec[3] = '{OP_ADD, 8'h00, 8'h00, 1'b0, 9'h000};
    vec[4] = '{OP_ADD, 8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vec[5] = '{OP_SUB, 8'h00, 8'hFF, 1'b1, 9'h101};
    vec[6] = '{OP_ADD, 8'h80, 8'h80, 1'b0, 9'h100};
    vec[7] = '{OP_SUB, 8'hFF, 8'h00, 1'b0, 9'h0FF};

    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d.valid", i), 32'(bus.out_valid), 0);
      check($sformatf("rst%0d.ready", i), 32'(bus.in_ready), 0);
      check($sformatf("rst%0d.acc", i), 32'(acc_count), 0);
      check($sformatf("rst%0d.sum", i), 32'(bus.out_sum), 0);
    end
    rst = 1'b0;
    #1;
    check("rst_release.ready", 32'(bus.in_ready), 1);

    // Single transactions through an empty queue.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].op, vec[i].a, vec[i].b, vec[i].cin, 1'b1);
      tick();
      drive(vec[i].op, ~vec[i].a, ~vec[i].b, vec[i].cin, 1'b0);
      check($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 1);
      check($sformatf("vec%0d.sum", i), 32'(bus.out_sum), 32'(vec[i].exp));
      check($sformatf("vec%0d.acc", i), 32'(acc_count), 32'(i + 1));
      tick();
      check($sformatf("vec%0d.drain", i), 32'(bus.out_valid), 0);
    end

    // Back-pressure: fill, hold third, then drain in order.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 8'd1, 8'd1, 1'b0, 1'b1);
    tick();
    check("full.ready1", 32'(bus.in_ready), 1);
    check("full.sum1", 32'(bus.out_sum), 9'h002);
    drive(OP_ADD, 8'd2, 8'd2, 1'b0, 1'b1);
    tick();
    check("full.ready2", 32'(bus.in_ready), 0);
    drive(OP_ADD, 8'd3, 8'd3, 1'b0, 1'b1);
    tick();
    check("full.held_ready", 32'(bus.in_ready), 0);
    check("full.held_sum", 32'(bus.out_sum), 9'h002);
    check("full.held_acc", 32'(acc_count), 10);
    bus.out_ready = 1'b1;
    tick();
    check("full.pop_ready", 32'(bus.in_ready), 1);
    check("full.pop_sum", 32'(bus.out_sum), 9'h004);
    tick();
    check("full.third_sum", 32'(bus.out_sum), 9'h006);
    check("full.third_acc", 32'(acc_count), 11);
    drive(OP_ADD, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("full.empty", 32'(bus.out_valid), 0);

    // Occupancy one: accept and pop on the same edge.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 8'd10, 8'd20, 1'b0, 1'b1);
    tick();
    check("occ1.sum_first", 32'(bus.out_sum), 9'h01E);
    bus.out_ready = 1'b1;
    drive(OP_SUB, 8'd9, 8'd4, 1'b1, 1'b1);
    tick();
    check("occ1.valid", 32'(bus.out_valid), 1);
    check("occ1.sum_new", 32'(bus.out_sum), 9'h005);
    check("occ1.ready", 32'(bus.in_ready), 1);
    drive(OP_ADD, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("occ1.empty", 32'(bus.out_valid), 0);
    check("occ1.acc", 32'(acc_count), 13);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      check_model($sformatf("rnd%0d", i));
      drive(op_e'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom);
      tick();
    end

    // Reset with two results queued discards them.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 8'd1, 8'd2, 1'b0, 1'b1);
    tick();
    tick();
    drive(OP_ADD, 8'd3, 8'd4, 1'b0, 1'b1);
    tick();
    check("mid.full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    drive(OP_ADD, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    check("mid.rst_ready", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid.valid", 32'(bus.out_valid), 0);
    check("mid.acc", 32'(acc_count), 0);
    check("mid.sum", 32'(bus.out_sum), 0);
    check("mid.ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid.after%0d", i), 32'(bus.out_valid), 0);
    end

    // Counter saturation.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      drive(op_e'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    check("sat.acc", 32'(acc_count), 32'h0000_FFFF);
    check_model("sat");
    tick();
    check("sat.hold", 32'(acc_count), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_resp.md
ADDER_RESP -- requirements
Module: adder_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, result queue depth in entries (DEPTH >= 2).
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand transaction present.
REQ-007 in_ready  output  1  block can accept an operand transaction.
REQ-008 in_op  input  op_e (1)  OP_ADD=0, OP_SUB=1.
REQ-009 in_a  input  WIDTH  operand A, unsigned.
REQ-010 in_b  input  WIDTH  operand B, unsigned.
REQ-011 in_cin  input  1  carry-in, OP_ADD only.
REQ-012 out_valid  output  1  result at head of queue.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 out_sum  output  WIDTH+1  result; MSB is carry (ADD) or borrow (SUB).
REQ-015 acc_count  output  16  accepted-transaction count, saturating.

Function
REQ-016 Accept when in_valid && in_ready at a rising edge; pop when out_valid && out_ready at a rising edge.
REQ-017 in_ready SHALL be 1 iff queue occupancy < DEPTH and rst is 0 (combinational from occupancy and rst only, never from out_ready).
REQ-018 OP_ADD: out_sum = zero-extended in_a + in_b + in_cin, WIDTH+1 bits, no truncation.
REQ-019 OP_SUB: out_sum = (WIDTH+1)-bit two's-complement in_a - in_b; in_cin ignored.
REQ-020 Latency: result of a transaction accepted at edge N SHALL be visible on out_sum with out_valid=1 immediately after edge N when the queue was empty.
REQ-021 Results SHALL leave in strict acceptance order; no loss, no duplication.
REQ-022 out_sum and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous accept and pop SHALL leave occupancy unchanged and keep order.
REQ-024 Full (occupancy = DEPTH): in_ready=0; a transaction presented is held by the initiator, not dropped; in_ready returns to 1 immediately after the edge that pops.
REQ-025 Empty: out_valid=0; out_ready ignored.
REQ-026 Queue read/write pointers SHALL wrap modulo DEPTH.
REQ-027 acc_count SHALL increment by 1 per accept and hold at 16'hFFFF once reached.
REQ-028 Inputs sampled only on accept; in_a/in_b/in_op changes without accept SHALL have no effect.

Reset
REQ-029 While rst=1 at an edge: occupancy=0, pointers=0, out_valid=0, acc_count=0, in_ready=0.
REQ-030 out_sum SHALL read 0 after reset until the first result is enqueued.
REQ-031 Reset mid-operation SHALL discard all queued results; no result accepted before reset SHALL appear afterwards.
REQ-032 First accept possible at the first edge with rst=0.

Structure
REQ-033 Package adder_pkg SHALL hold typedef op_e (OP_ADD, OP_SUB) and constant DEFAULT_WIDTH=8.
REQ-034 Result queue SHALL be sub-module adder_fifo (parameters DEPTH, DW) with push/pop/full/empty/count; arithmetic in adder_resp.
REQ-035 No latches; all state in a single clk domain.

Verification
REQ-036 rst=1 for 3 cycles -> out_valid=0, in_ready=0, acc_count=0; in_ready=1 in first cycle after rst falls.
REQ-037 ADD a=8'hFF b=8'h01 cin=1, out_ready=1 -> out_valid=1 after accept edge, out_sum=9'h101, acc_count=1.
REQ-038 SUB a=8'h05 b=8'h07 cin=1 -> out_sum=9'h1FE; SUB a=8'h07 b=8'h05 -> 9'h002.
REQ-039 out_ready=0, ADDs (1,1),(2,2),(3,3) back-to-back -> first two accepted, in_ready=0, third held; out_ready=1 -> 9'h002, 9'h004, 9'h006 in order, acc_count=3.
REQ-040 Occupancy 1, accept and pop same edge -> occupancy stays 1, next out_sum is new result, in_ready stays 1.
REQ-041 Two results queued, rst pulsed 1 cycle -> out_valid=0 next cycle, acc_count=0, queued results never appear; counter preloaded via 65536 accepts -> acc_count holds 16'hFFFF.
